alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Downstream neighbour of the ALU in the execute path.
- Accepts the ALU result, its zero/carry/overflow flags and the destination tag through a valid/ready handshake.
- Buffers them in a 2-entry skid buffer and presents them to the register-file write port with a second valid/ready handshake.
- Holds the architectural NZCV status register, updated on flag-setting operations, and evaluates branch conditions against it.

Parameters:
DATA_W, 32, width of result and write-back data
RD_W, 4, width of destination register index

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  ALU output is valid this cycle
in_ready  out  1  stage can accept an entry
in_result  in  DATA_W  ALU result
in_zero  in  1  ALU zero flag
in_carry  in  1  ALU carry flag
in_overflow  in  1  ALU overflow flag
in_rd  in  RD_W  destination register index
in_we  in  1  entry writes the register file
in_setflags  in  1  entry updates NZCV
wb_valid  out  1  write-back entry valid
wb_ready  in  1  register file accepts entry
wb_data  out  DATA_W  write-back data
wb_rd  out  RD_W  write-back register index
wb_we  out  1  write enable of the presented entry
flags_q  out  4  {N,Z,C,V} status register
cond  in  4  condition code to evaluate
cond_true  out  1  cond evaluated against flags_q (combinational)
occupancy  out  2  entries held (0..2)

Behaviour:
- Reset (reset=0, asynchronous): both entries invalid, occupancy=0, wb_valid=0, in_ready=1, flags_q=4'b0000, wb_data/wb_rd/wb_we=0.
- Reset mid-operation discards all held entries. No write-back is issued for them.
- Input accept happens when in_valid && in_ready. Output transfer happens when wb_valid && wb_ready.
- Storage: main register (drives wb_*) and skid register.
- in_ready = !skid_valid, registered. It is not combinationally dependent on wb_ready.
- Latency: an accepted entry appears on wb_* the next cycle when main is empty or drains the same cycle.
- Accept, main empty: entry goes to main.
- Accept, main full, no drain: entry goes to skid, in_ready drops next cycle.
- Accept and drain same cycle, skid empty: entry goes to main, occupancy unchanged.
- Drain with skid full: skid moves to main, in_ready=1 next cycle.
- Simultaneous accept and drain when skid full cannot occur, because in_ready=0.
- Entry order is strictly FIFO. wb_* holds stable while wb_valid && !wb_ready.
- occupancy = main_valid + skid_valid.
- Flags update at input accept, independent of write-back back-pressure, so a following branch sees the flags at once.
- If accept && in_setflags: N=in_result[DATA_W-1], Z=in_zero, C=in_carry, V=in_overflow.
- If accept && !in_setflags, or no accept: flags_q holds.
- Entries with in_we=0 still occupy the buffer and drain with wb_we=0. This lets flag-only ops (compare) flow in order.
- cond encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0

Test Plan:
- Reset with flags previously 4'b1111 and 2 entries held -> flags_q=0, occupancy=0, wb_valid=0, in_ready=1 immediately, asynchronously.
- Single accept: in_result=32'h0000_0005, rd=3, we=1, setflags=1, zero=0, with wb_ready=1 -> next cycle wb_valid=1, wb_data=5, wb_rd=3, flags_q=4'b0000.
- Back-pressure: wb_ready=0, accept A=32'h11 then B=32'h22 -> occupancy=2, in_ready=0. Release wb_ready -> A then B on consecutive cycles, in_ready returns 1 after A drains.
- Flag semantics: accept result 32'h8000_0000 with carry=1, overflow=1, setflags=1 -> flags_q=4'b1011, cond=11 (LT) gives 0, cond=4 (MI) gives 1. Then accept with setflags=0 -> flags_q unchanged.
- Streaming: in_valid=1, wb_ready=1 for 10 cycles with results 1..10 -> 10 write-backs in order, occupancy stays 1, in_ready never drops.
- Compare op: in_we=0, setflags=1, zero=1 -> Z=1 next cycle, cond=0 true, wb_valid=1 with wb_we=0.

Source files
------------

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU write-back stage: 2-entry skid buffer, NZCV register, branch condition evaluation.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              in_setflags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic [3:0]        flags_q,
  input  logic [3:0]        cond,
  output logic              cond_true,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [RD_W-1:0]   main_rd;
  logic              main_we;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;
  logic              skid_we;

  logic accept;
  logic drain;

  // in_ready comes straight from a flop, so it never depends on wb_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && wb_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_rd    <= '0;
      main_we    <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_rd    <= skid_rd;
        main_we    <= skid_we;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_result;
        main_rd    <= in_rd;
        main_we    <= in_we;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept && !main_valid) begin
      main_valid <= 1'b1;
      main_data  <= in_result;
      main_rd    <= in_rd;
      main_we    <= in_we;
    end
  end

  // Skid only fills when main is held by back-pressure; it empties on the next drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_rd    <= '0;
      skid_we    <= 1'b0;
    end else if (drain) begin
      skid_valid <= 1'b0;
    end else if (accept && main_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_result;
      skid_rd    <= in_rd;
      skid_we    <= in_we;
    end
  end

  // Flags follow the accept, not the drain, so a dependent branch sees them immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (accept && in_setflags) begin
      flags_q <= {in_result[DATA_W-1], in_zero, in_carry, in_overflow};
    end
  end

  assign wb_valid  = main_valid;
  assign wb_data   = main_data;
  assign wb_rd     = main_rd;
  assign wb_we     = main_we;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = flag_z;
      4'd1:    cond_true = !flag_z;
      4'd2:    cond_true = flag_c;
      4'd3:    cond_true = !flag_c;
      4'd4:    cond_true = flag_n;
      4'd5:    cond_true = !flag_n;
      4'd6:    cond_true = flag_v;
      4'd7:    cond_true = !flag_v;
      4'd8:    cond_true = flag_c && !flag_z;
      4'd9:    cond_true = !flag_c || flag_z;
      4'd10:   cond_true = (flag_n == flag_v);
      4'd11:   cond_true = (flag_n != flag_v);
      4'd12:   cond_true = !flag_z && (flag_n == flag_v);
      4'd13:   cond_true = flag_z || (flag_n != flag_v);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed self-checking bench for alu_writeback.
module tb_alu_writeback;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_carry;
  logic        in_overflow;
  logic [3:0]  in_rd;
  logic        in_we;
  logic        in_setflags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  logic [3:0]  flags_q;
  logic [3:0]  cond;
  logic        cond_true;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [15:0] cond_exp;

  alu_writeback #(.DATA_W(32), .RD_W(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_carry(in_carry), .in_overflow(in_overflow),
    .in_rd(in_rd), .in_we(in_we), .in_setflags(in_setflags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .flags_q(flags_q),
    .cond(cond), .cond_true(cond_true), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic z, input logic c,
                       input logic o, input logic [3:0] rd, input logic we, input logic sf);
    in_valid    = v;
    in_result   = r;
    in_zero     = z;
    in_carry    = c;
    in_overflow = o;
    in_rd       = rd;
    in_we       = we;
    in_setflags = sf;
  endtask

  initial begin
    reset = 1'b0;
    wb_ready = 1'b0;
    cond = 4'd0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #12;
    check("rst_flags", {28'h0, flags_q}, 32'h0);
    check("rst_occ", {30'h0, occupancy}, 32'd0);
    check("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_wb_data", wb_data, 32'h0);
    reset = 1'b1;
    cyc();

    // Single accept
    wb_ready = 1'b1;
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("single_valid", {31'h0, wb_valid}, 32'd1);
    check("single_data", wb_data, 32'h5);
    check("single_rd", {28'h0, wb_rd}, 32'd3);
    check("single_we", {31'h0, wb_we}, 32'd1);
    check("single_flags", {28'h0, flags_q}, 32'h0);
    check("single_occ", {30'h0, occupancy}, 32'd1);
    cyc();
    check("single_drained", {31'h0, wb_valid}, 32'd0);

    // Back-pressure
    wb_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    cyc();
    check("bp_occ1", {30'h0, occupancy}, 32'd1);
    check("bp_ready1", {31'h0, in_ready}, 32'd1);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("bp_occ2", {30'h0, occupancy}, 32'd2);
    check("bp_ready0", {31'h0, in_ready}, 32'd0);
    check("bp_hold_a", wb_data, 32'h11);
    cyc();
    check("bp_still_a", wb_data, 32'h11);
    check("bp_still_rd", {28'h0, wb_rd}, 32'd1);
    wb_ready = 1'b1;
    cyc();
    check("bp_b_data", wb_data, 32'h22);
    check("bp_b_rd", {28'h0, wb_rd}, 32'd2);
    check("bp_ready_back", {31'h0, in_ready}, 32'd1);
    check("bp_occ_after_a", {30'h0, occupancy}, 32'd1);
    cyc();
    check("bp_empty", {30'h0, occupancy}, 32'd0);

    // Flag semantics
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1);
    cyc();
    check("flags_1011", {28'h0, flags_q}, 32'hB);
    cond = 4'd11;
    #1;
    check("cond_lt", {31'h0, cond_true}, 32'd0);
    cond = 4'd4;
    #1;
    check("cond_mi", {31'h0, cond_true}, 32'd1);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("flags_hold", {28'h0, flags_q}, 32'hB);
    cyc();

    // Streaming
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
      cyc();
      check("stream_data", wb_data, i);
      check("stream_occ", {30'h0, occupancy}, 32'd1);
      check("stream_ready", {31'h0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_empty", {30'h0, occupancy}, 32'd0);

    // Compare op
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("cmp_flags", {28'h0, flags_q}, 32'h4);
    check("cmp_valid", {31'h0, wb_valid}, 32'd1);
    check("cmp_we", {31'h0, wb_we}, 32'd0);
    cond_exp = 16'h66A9;
    for (int c = 0; c < 16; c++) begin
      cond = c[3:0];
      #1;
      check("cond_table", {31'h0, cond_true}, {31'h0, cond_exp[c]});
    end
    cyc();

    // Asynchronous reset with two entries held
    wb_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
    cyc();
    cyc();
    in_valid = 1'b0;
    check("pre_rst_occ", {30'h0, occupancy}, 32'd2);
    check("pre_rst_flags", {28'h0, flags_q}, 32'hF);
    #2;
    reset = 1'b0;
    #1;
    check("arst_flags", {28'h0, flags_q}, 32'h0);
    check("arst_occ", {30'h0, occupancy}, 32'd0);
    check("arst_valid", {31'h0, wb_valid}, 32'd0);
    check("arst_ready", {31'h0, in_ready}, 32'd1);
    check("arst_data", wb_data, 32'h0);
    #3;
    reset = 1'b1;
    wb_ready = 1'b1;
    cyc();
    check("post_rst_valid", {31'h0, wb_valid}, 32'd0);
    check("post_rst_occ", {30'h0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
